// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the core store port and dmem, with store-to-load forwarding.
// Define STORE_BUF_COALESCE_EN to merge a same-word store into the youngest pending entry.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     memwrite,
   input  logic [AW-1:0]            dataadr,
   input  logic [DW-1:0]            writedata,
   output logic                     full,
   input  logic [AW-1:0]            ld_addr,
   output logic                     fwd_hit,
   output logic [DW-1:0]            fwd_data,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [DW-1:0]            mem_wdata,
   input  logic                     mem_ready,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          drain_s, enq_s, coal_s, wr_en_s;
   logic [PW-1:0] wr_idx_s;
   logic [PW-1:0] fwd_idx_s;

   // Word-granular compare; byte-offset bits are shifted out.
   function automatic logic word_match(input logic [AW-1:0] a, input logic [AW-1:0] b);
      return ((a ^ b) >> 2) == {AW{1'b0}};
   endfunction

   assign full      = (count_q == CW'(DEPTH));
   assign mem_we    = (count_q != {CW{1'b0}});
   assign mem_addr  = mem_we ? addr_q[rd_ptr_q] : {AW{1'b0}};
   assign mem_wdata = mem_we ? data_q[rd_ptr_q] : {DW{1'b0}};
   assign overflow  = overflow_q;
   assign count     = count_q;
   assign drain_s   = mem_we & mem_ready;

`ifdef STORE_BUF_COALESCE_EN
   logic [PW-1:0] tail_s;
   assign tail_s   = wr_ptr_q - PW'(1);
   // The head leaving this cycle cannot absorb a store; it would be lost.
   assign coal_s   = memwrite & mem_we & word_match(addr_q[tail_s], dataadr)
                     & ~(drain_s & (count_q == CW'(1)));
   assign wr_idx_s = coal_s ? tail_s : wr_ptr_q;
`else
   assign coal_s   = 1'b0;
   assign wr_idx_s = wr_ptr_q;
`endif

   assign enq_s   = memwrite & ~full & ~coal_s;
   assign wr_en_s = enq_s | coal_s;

   // Next-state for pointers, occupancy and the sticky overflow flag.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (enq_s) wr_ptr_d = wr_ptr_q + PW'(1);
      else       wr_ptr_d = wr_ptr_q;
      if (drain_s) rd_ptr_d = rd_ptr_q + PW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({enq_s, drain_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      if (memwrite & full & ~coal_s) overflow_d = 1'b1;
      else                           overflow_d = overflow_q;
   end

   // Forwarding scan oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit   = 1'b0;
      fwd_data  = {DW{1'b0}};
      fwd_idx_s = rd_ptr_q;
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx_s = rd_ptr_q + PW'(k);
         if ((CW'(k) < count_q) && word_match(addr_q[fwd_idx_s], ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx_s];
         end else begin
            fwd_hit  = fwd_hit;
            fwd_data = fwd_data;
         end
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= {PW{1'b0}};
         rd_ptr_q   <= {PW{1'b0}};
         count_q    <= {CW{1'b0}};
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Entry storage; validity comes from count, so no reset is needed here.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         addr_q[wr_idx_s] <= dataadr;
         data_q[wr_idx_s] <= writedata;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed test-plan steps plus random traffic checked against a queue model.
module tb_store_buffer;
   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, memwrite, mem_ready;
   logic [AW-1:0] dataadr, ld_addr;
   logic [DW-1:0] writedata;
   logic          full, fwd_hit, mem_we, overflow;
   logic [DW-1:0] fwd_data, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [CW-1:0] count;

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
      .writedata(writedata), .full(full), .ld_addr(ld_addr), .fwd_hit(fwd_hit),
      .fwd_data(fwd_data), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .overflow(overflow), .count(count)
   );

   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
   ent_t q[$];
   bit   m_ovf;
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set(input bit mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit rdy, input logic [AW-1:0] ld);
      memwrite = mw; dataadr = a; writedata = d; mem_ready = rdy; ld_addr = ld;
   endtask

   // Compare every output against the queue model.
   task automatic chk_model();
      bit            e_hit;
      logic [DW-1:0] e_fwd;
      e_hit = 0; e_fwd = '0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!e_hit && (q[i].a >> 2) == (ld_addr >> 2)) begin
            e_hit = 1; e_fwd = q[i].d;
         end
      end
      chk("m_full",   64'(full),      64'(q.size() == DEPTH));
      chk("m_we",     64'(mem_we),    64'(q.size() != 0));
      chk("m_addr",   64'(mem_addr),  (q.size() != 0) ? 64'(q[0].a) : 64'd0);
      chk("m_wdata",  64'(mem_wdata), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
      chk("m_hit",    64'(fwd_hit),   64'(e_hit));
      chk("m_fwd",    64'(fwd_data),  64'(e_fwd));
      chk("m_ovf",    64'(overflow),  64'(m_ovf));
      chk("m_count",  64'(count),     64'(q.size()));
   endtask

   // Advance one clock edge and apply the same edge to the model.
   task automatic tick();
      bit drain, coal, push;
      @(posedge clk);
      if (reset) begin
         q.delete();
         m_ovf = 0;
      end else begin
         drain = (q.size() != 0) && mem_ready;
         coal  = 0;
         push  = 0;
`ifdef STORE_BUF_COALESCE_EN
         if (memwrite && q.size() != 0 && (q[q.size()-1].a >> 2) == (dataadr >> 2)
             && !(drain && q.size() == 1)) coal = 1;
`endif
         if (memwrite && coal) begin
            q[q.size()-1].a = dataadr;
            q[q.size()-1].d = writedata;
         end else if (memwrite) begin
            if (q.size() < DEPTH) push = 1;
            else m_ovf = 1;
         end
         if (drain) void'(q.pop_front());
         if (push) q.push_back('{dataadr, writedata});
      end
      @(negedge clk);
   endtask

   task automatic cyc(input bit mw, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input bit rdy, input logic [AW-1:0] ld);
      set(mw, a, d, rdy, ld);
      #1;
      chk_model();
      tick();
   endtask

   initial begin
      int n0;
      logic [AW-1:0] ra;
      reset = 1'b1;
      set(1'b0, '0, '0, 1'b0, '0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_we",    64'(mem_we), 64'd0);
      chk("rst_addr",  64'(mem_addr), 64'd0);
      chk("rst_full",  64'(full), 64'd0);
      chk("rst_ovf",   64'(overflow), 64'd0);
      chk("rst_hit",   64'(fwd_hit), 64'd0);

      // Single store, drained next cycle.
      cyc(1'b1, 32'd84, 32'd7, 1'b1, 32'd0);
      set(1'b0, '0, '0, 1'b1, 32'd0);
      #1;
      chk("t1_we",    64'(mem_we), 64'd1);
      chk("t1_addr",  64'(mem_addr), 64'd84);
      chk("t1_wdata", 64'(mem_wdata), 64'd7);
      tick();
      #1;
      chk("t1_count", 64'(count), 64'd0);
      chk("t1_we0",   64'(mem_we), 64'd0);

      // Fill, overflow, ordered drain.
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(80 + 4 * i), 32'(i + 1), 1'b0, 32'd0);
      set(1'b0, '0, '0, 1'b0, 32'd0);
      #1;
      chk("t2_full",  64'(full), 64'd1);
      chk("t2_count", 64'(count), 64'd4);
      cyc(1'b1, 32'd96, 32'hDEAD, 1'b0, 32'd96);
      set(1'b0, '0, '0, 1'b0, 32'd96);
      #1;
      chk("t2_ovf",   64'(overflow), 64'd1);
      chk("t2_cnt4",  64'(count), 64'd4);
      chk("t2_nofwd", 64'(fwd_hit), 64'd0);
      for (int i = 0; i < 4; i++) begin
         set(1'b0, '0, '0, 1'b1, 32'd0);
         #1;
         chk("t2_order", 64'(mem_addr), 64'(80 + 4 * i));
         tick();
      end
      #1;
      chk("t2_empty", 64'(count), 64'd0);

      // Forwarding: youngest same-word entry wins.
      cyc(1'b1, 32'd80, 32'd5, 1'b0, 32'd0);
      cyc(1'b1, 32'd80, 32'd9, 1'b0, 32'd0);
      set(1'b0, '0, '0, 1'b0, 32'd82);
      #1;
      chk("t3_hit",  64'(fwd_hit), 64'd1);
      chk("t3_data", 64'(fwd_data), 64'd9);
`ifdef STORE_BUF_COALESCE_EN
      chk("t3_count", 64'(count), 64'd1);
`else
      chk("t3_count", 64'(count), 64'd2);
`endif
      set(1'b0, '0, '0, 1'b0, 32'd100);
      #1;
      chk("t3_miss",  64'(fwd_hit), 64'd0);
      chk("t3_mdata", 64'(fwd_data), 64'd0);

      // Simultaneous enqueue and drain.
      n0 = q.size();
      cyc(1'b1, 32'd88, 32'd3, 1'b1, 32'd88);
      #1;
      chk("t4_same", 64'(count), 64'(n0));
      for (int i = 0; q.size() < DEPTH && i < 8; i++) cyc(1'b1, 32'(256 + 4 * i), 32'(i), 1'b0, 32'd0);
      set(1'b1, 32'h200, 32'h55, 1'b1, 32'h200);
      #1;
      chk("t4_full", 64'(full), 64'd1);
      tick();
      #1;
      chk("t4_cnt3", 64'(count), 64'(DEPTH - 1));
      chk("t4_ovf",  64'(overflow), 64'd1);
      chk_model();

      // Reset mid-operation with pending stores.
      reset = 1'b1;
      set(1'b0, '0, '0, 1'b1, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_we",    64'(mem_we), 64'd0);
      chk("t5_ovf",   64'(overflow), 64'd0);

      // Same-word back-to-back stores.
      cyc(1'b1, 32'd80, 32'd1, 1'b0, 32'd0);
      cyc(1'b1, 32'd80, 32'd2, 1'b0, 32'd0);
      set(1'b0, '0, '0, 1'b0, 32'd0);
      #1;
`ifdef STORE_BUF_COALESCE_EN
      chk("t6_count", 64'(count), 64'd1);
      chk("t6_wdata", 64'(mem_wdata), 64'd2);
`else
      chk("t6_count", 64'(count), 64'd2);
      chk("t6_wdata", 64'(mem_wdata), 64'd1);
`endif

      // Random traffic against the model.
      for (int n = 0; n < 400; n++) begin
         reset = ($urandom_range(0, 60) == 0);
         ra = 32'h80 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
         cyc($urandom_range(0, 3) != 0, ra, $urandom, $urandom_range(0, 2) == 0,
             32'h80 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3)));
      end
      reset = 1'b0;
      #1;
      chk_model();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the RISC-V core's store port (memwrite, dataadr, writedata) and data memory.
- Core stores retire in one cycle into the buffer; the buffer drains to dmem through a valid/ready handshake.
- Younger loads get store-to-load forwarding from pending entries, so memory ordering stays correct while dmem is slow.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- AW, 32, address width.
- DW, 32, data width (one word per entry).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- memwrite  in  1  core store request this cycle.
- dataadr  in  AW  core store address (byte address).
- writedata  in  DW  core store data.
- full  out  1  buffer holds DEPTH entries; the core must stall stores.
- ld_addr  in  AW  core load address, for the forwarding lookup.
- fwd_hit  out  1  a pending entry matches ld_addr.
- fwd_data  out  DW  data of the youngest matching entry; 0 when fwd_hit=0.
- mem_we  out  1  drain request valid (head entry present).
- mem_addr  out  AW  head entry address.
- mem_wdata  out  DW  head entry data.
- mem_ready  in  1  dmem accepts the head entry this cycle.
- overflow  out  1  sticky flag: a store arrived while full.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset
  - Clears wr_ptr, rd_ptr, count and overflow; all entries become invalid.
  - Outputs after reset: full=0, mem_we=0, mem_addr=0, mem_wdata=0, fwd_hit=0, fwd_data=0, overflow=0, count=0.
  - Reset asserted mid-operation discards pending stores. No drain beats are issued during reset.
- Address matching
  - Word granular: compare dataadr[AW-1:2] against ld_addr[AW-1:2].
  - Stored addresses keep full width; bits [1:0] pass through to mem_addr unchanged.
- Enqueue
  - memwrite=1 and full=0: write {dataadr, writedata} at wr_ptr on the clock edge; wr_ptr advances modulo DEPTH.
  - memwrite=1 and full=1: store dropped, no state change except overflow<=1.
- Drain
  - mem_we = (count != 0), purely combinational.
  - mem_addr and mem_wdata show the head entry when count != 0, else 0.
  - A beat completes when mem_we & mem_ready at the edge; rd_ptr advances.
  - mem_ready while empty is ignored.
- Simultaneous events
  - Enqueue and drain in the same cycle (not full): count unchanged, both pointers advance.
  - When full, a same-cycle drain does NOT admit the incoming store. full is computed from count only, with no combinational path from mem_ready to full.
- Latency
  - A store accepted at edge N appears on mem_we/mem_addr at cycle N+1 at the earliest, when the buffer was empty.
  - Occupancy is visible on count in the cycle after the edge.
- Forwarding (combinational)
  - Scan all valid entries; the youngest (closest to wr_ptr) with a word-address match drives fwd_data and sets fwd_hit.
  - The head entry being drained this cycle still forwards.
  - The store being enqueued in the same cycle is NOT forwarded.
- Pointer wrap
  - Pointers wrap from DEPTH-1 to 0.
  - Full and empty are distinguished by count, never by pointer equality.
- FSM-free; state is pointers, count, entry array and the sticky flag.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined:
  - Applies when a store's word address equals the youngest entry's and that entry is not the head being accepted this cycle (mem_we & mem_ready & count==1).
  - Such a store overwrites that entry's data and address instead of allocating; count unchanged.
  - Coalescing also applies while full, with no overflow.
- Undefined: every accepted store allocates a new entry.

Test Plan:
- Reset, then single store: reset high 2 cycles, then memwrite with addr 84, data 7, mem_ready=1 → next cycle mem_we=1, mem_addr=84, mem_wdata=7; cycle after that, count=0 and mem_we=0.
- Fill and stall: mem_ready=0, stores to 80, 84, 88, 92 → full=1, count=4. A 5th store (96, 0xDEAD) → dropped, overflow=1, and entries drain in order 80, 84, 88, 92 once mem_ready=1.
- Forwarding youngest wins: stores (80, 5) then (80, 9) with mem_ready=0, ld_addr=82 → fwd_hit=1, fwd_data=9 (without the macro, count=2). ld_addr=100 → fwd_hit=0, fwd_data=0.
- Simultaneous enqueue/drain: count=2, mem_ready=1, memwrite (88, 3) → count stays 2; full=1 with mem_ready=1 plus a store → store dropped, count=3, overflow=1.
- Reset mid-operation: 3 pending stores, reset pulsed 1 cycle → count=0, mem_we=0, overflow=0, and no beat issued on the reset edge.
- STORE_BUF_COALESCE_EN: mem_ready=0, stores (80, 1), (80, 2) → count=1, mem_wdata=2. Repeat with the macro undefined → count=2.
